// File: rtl/approx_mult_pkg.sv
// Shared constants for the leading-one truncating approximate multiplier.
// Used by the controller, the datapath and the top level.
package approx_mult_pkg;

  localparam int N  = 16;
  localparam int H  = 8;
  localparam int CW = 5;

  localparam logic [CW-1:0] CNT_MAX = '1;

endpackage

// File: rtl/approx_mult_datapath_if.sv
// Control, operand and status bundle between the one-hot controller (master)
// and the approximate multiplier datapath (slave).
import approx_mult_pkg::*;

interface approx_mult_datapath_if;

  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           rst5;
  logic           loadA;
  logic           loadB;
  logic           shlA;
  logic           shlB;
  logic           cntU;
  logic           cntD;
  logic           loadOut;
  logic           shrOut;
  logic           DoneA;
  logic           DoneB;
  logic           downDone;
  logic [2*N-1:0] result;

  modport master (
    output A, B, rst5, loadA, loadB, shlA, shlB, cntU, cntD, loadOut, shrOut,
    input  DoneA, DoneB, downDone, result
  );

  modport slave (
    input  A, B, rst5, loadA, loadB, shlA, shlB, cntU, cntD, loadOut, shrOut,
    output DoneA, DoneB, downDone, result
  );

endinterface

// File: rtl/approx_mult_datapath_shift_reg_ld.sv
// Loadable shift register with zero fill; load beats either shift.
module shift_reg_ld #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shl,
  input  logic         shr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shl) begin
      q_d = {q_q[W-2:0], 1'b0};
    end else if (shr) begin
      q_d = {1'b0, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/approx_mult_datapath.sv
// Datapath of the leading-one truncating approximate multiplier: normalise both
// operands, multiply their top halves, then shift the product back down.
import approx_mult_pkg::*;

module approx_mult_datapath (
  input  logic                  clk,
  input  logic                  rst,
  approx_mult_datapath_if.slave dp
);

  logic [N-1:0]   reg_a;
  logic [N-1:0]   reg_b;
  logic [2*N-1:0] reg_out;
  logic [2*H-1:0] prod;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;

  shift_reg_ld #(.W(N)) u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .load (dp.loadA),
    .shl  (dp.shlA),
    .shr  (1'b0),
    .d    (dp.A),
    .q    (reg_a)
  );

  shift_reg_ld #(.W(N)) u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .load (dp.loadB),
    .shl  (dp.shlB),
    .shr  (1'b0),
    .d    (dp.B),
    .q    (reg_b)
  );

  // Only the normalised top halves feed the multiplier; the low bits are dropped.
  assign prod = (2*H)'(reg_a[N-1:N-H]) * (2*H)'(reg_b[N-1:N-H]);

  shift_reg_ld #(.W(2*N)) u_reg_out (
    .clk  (clk),
    .rst  (rst),
    .load (dp.loadOut),
    .shl  (1'b0),
    .shr  (dp.shrOut),
    .d    ({prod, {(2*N-2*H){1'b0}}}),
    .q    (reg_out)
  );

  // Up and down together cancel; both directions saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (dp.rst5) begin
      cnt_d = '0;
    end else if (dp.cntU && dp.cntD) begin
      cnt_d = cnt_q;
    end else if (dp.cntU) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (dp.cntD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dp.DoneA    = reg_a[N-1] | (reg_a == '0);
  assign dp.DoneB    = reg_b[N-1] | (reg_b == '0);
  assign dp.downDone = (cnt_q == '0);
  assign dp.result   = reg_out;

endmodule

// File: tb/tb_approx_mult_datapath.sv
// Directed self-checking bench for approx_mult_datapath, acting as the controller.
import approx_mult_pkg::*;

module tb_approx_mult_datapath;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  approx_mult_datapath_if dp_if ();

  approx_mult_datapath dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_ctrl();
    dp_if.rst5    = 1'b0;
    dp_if.loadA   = 1'b0;
    dp_if.loadB   = 1'b0;
    dp_if.shlA    = 1'b0;
    dp_if.shlB    = 1'b0;
    dp_if.cntU    = 1'b0;
    dp_if.cntD    = 1'b0;
    dp_if.loadOut = 1'b0;
    dp_if.shrOut  = 1'b0;
  endtask

  // Apply whatever controls are set for one edge, then sample #1 later and drop them.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctrl();
    rst = 1'b0;
  endtask

  task automatic load_ops(input logic [N-1:0] a, input logic [N-1:0] b);
    dp_if.A     = a;
    dp_if.B     = b;
    dp_if.loadA = 1'b1;
    dp_if.loadB = 1'b1;
    dp_if.rst5  = 1'b1;
    tick();
  endtask

  task automatic run_full(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int na, output int nb, output int nd,
                          output logic [2*N-1:0] loaded, output logic [2*N-1:0] fin);
    load_ops(a, b);
    na = 0;
    while (!dp_if.DoneA && na < 40) begin
      dp_if.shlA = 1'b1;
      dp_if.cntU = 1'b1;
      tick();
      na++;
    end
    nb = 0;
    while (!dp_if.DoneB && nb < 40) begin
      dp_if.shlB = 1'b1;
      dp_if.cntU = 1'b1;
      tick();
      nb++;
    end
    dp_if.loadOut = 1'b1;
    tick();
    loaded = dp_if.result;
    nd = 0;
    while (!dp_if.downDone && nd < 40) begin
      dp_if.shrOut = 1'b1;
      dp_if.cntD   = 1'b1;
      tick();
      nd++;
    end
    fin = dp_if.result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (dp_if.DoneA !== 1'b1 || dp_if.DoneB !== 1'b1 || dp_if.downDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_flags: got DoneA=%b DoneB=%b downDone=%b, want 1 1 1",
               dp_if.DoneA, dp_if.DoneB, dp_if.downDone);
    end
    total++;
    if (dp_if.result !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_result: got %h want 00000000", dp_if.result);
    end
  endtask

  task automatic test_small_ops();
    int na, nb, nd;
    logic [2*N-1:0] loaded, fin;
    run_full(16'h0003, 16'h0005, na, nb, nd, loaded, fin);
    total++;
    if (na !== 14) begin bad++; $display("[TB] FAIL small_shlA_count: got %0d want 14", na); end
    total++;
    if (nb !== 13) begin bad++; $display("[TB] FAIL small_shlB_count: got %0d want 13", nb); end
    total++;
    if (loaded !== 32'h7800_0000) begin
      bad++; $display("[TB] FAIL small_loadOut: got %h want 78000000", loaded);
    end
    total++;
    if (nd !== 27) begin bad++; $display("[TB] FAIL small_cnt_total: got %0d want 27", nd); end
    total++;
    if (fin !== 32'd15) begin bad++; $display("[TB] FAIL small_result: got %0d want 15", fin); end
  endtask

  task automatic test_all_ones();
    int na, nb, nd;
    logic [2*N-1:0] loaded, fin;
    run_full(16'hFFFF, 16'hFFFF, na, nb, nd, loaded, fin);
    total++;
    if (na !== 0 || nb !== 0) begin
      bad++; $display("[TB] FAIL ones_no_shift: got shlA=%0d shlB=%0d want 0 0", na, nb);
    end
    total++;
    if (nd !== 0) begin bad++; $display("[TB] FAIL ones_no_shr: got %0d want 0", nd); end
    total++;
    if (fin !== 32'hFE01_0000) begin
      bad++; $display("[TB] FAIL ones_result: got %h want fe010000", fin);
    end
  endtask

  task automatic test_zero_operand();
    int na, nb, nd;
    logic [2*N-1:0] loaded, fin;
    run_full(16'h0000, 16'h1234, na, nb, nd, loaded, fin);
    total++;
    if (na !== 0) begin bad++; $display("[TB] FAIL zero_doneA: got shlA=%0d want 0", na); end
    total++;
    if (nb !== 3) begin bad++; $display("[TB] FAIL zero_shlB_count: got %0d want 3", nb); end
    total++;
    if (loaded !== 32'h0 || fin !== 32'h0) begin
      bad++; $display("[TB] FAIL zero_result: got loaded=%h final=%h want 0 0", loaded, fin);
    end
  endtask

  task automatic test_priority();
    int na;
    dp_if.A     = 16'h0001;
    dp_if.B     = 16'h8000;
    dp_if.loadA = 1'b1;
    dp_if.shlA  = 1'b1;
    dp_if.loadB = 1'b1;
    dp_if.rst5  = 1'b1;
    tick();
    total++;
    if (dp_if.DoneA !== 1'b0) begin
      bad++; $display("[TB] FAIL prio_doneA: got %b want 0", dp_if.DoneA);
    end
    na = 0;
    while (!dp_if.DoneA && na < 40) begin
      dp_if.shlA = 1'b1;
      tick();
      na++;
    end
    total++;
    if (na !== 15) begin bad++; $display("[TB] FAIL prio_load_wins: got shifts=%0d want 15", na); end
    dp_if.cntU = 1'b1;
    tick();
    dp_if.cntU = 1'b1;
    dp_if.cntD = 1'b1;
    tick();
    total++;
    if (dp_if.downDone !== 1'b0) begin
      bad++; $display("[TB] FAIL prio_up_down_hold: got downDone=%b want 0", dp_if.downDone);
    end
    dp_if.cntD = 1'b1;
    tick();
    total++;
    if (dp_if.downDone !== 1'b1) begin
      bad++; $display("[TB] FAIL prio_down_to_zero: got downDone=%b want 1", dp_if.downDone);
    end
  endtask

  task automatic test_mid_reset();
    int na, nb, nd;
    logic [2*N-1:0] loaded, fin;
    load_ops(16'h0003, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      dp_if.shlA = 1'b1;
      dp_if.cntU = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    total++;
    if (dp_if.DoneA !== 1'b1 || dp_if.DoneB !== 1'b1 || dp_if.downDone !== 1'b1 ||
        dp_if.result !== 32'h0) begin
      bad++;
      $display("[TB] FAIL midreset_state: got DoneA=%b DoneB=%b downDone=%b result=%h want 1 1 1 0",
               dp_if.DoneA, dp_if.DoneB, dp_if.downDone, dp_if.result);
    end
    run_full(16'h0003, 16'h0005, na, nb, nd, loaded, fin);
    total++;
    if (na !== 14 || nb !== 13 || nd !== 27 || fin !== 32'd15) begin
      bad++;
      $display("[TB] FAIL midreset_rerun: got %0d %0d %0d %0d want 14 13 27 15", na, nb, nd, fin);
    end
  endtask

  task automatic test_counter_bounds();
    int nd;
    dp_if.rst5 = 1'b1;
    tick();
    dp_if.cntD = 1'b1;
    tick();
    total++;
    if (dp_if.downDone !== 1'b1) begin
      bad++; $display("[TB] FAIL cnt_down_at_zero: got downDone=%b want 1", dp_if.downDone);
    end
    dp_if.cntU = 1'b1;
    tick();
    dp_if.rst5 = 1'b1;
    dp_if.cntU = 1'b1;
    tick();
    total++;
    if (dp_if.downDone !== 1'b1) begin
      bad++; $display("[TB] FAIL cnt_rst5_wins: got downDone=%b want 1", dp_if.downDone);
    end
    for (int i = 0; i < 34; i++) begin
      dp_if.cntU = 1'b1;
      tick();
    end
    nd = 0;
    while (!dp_if.downDone && nd < 40) begin
      dp_if.cntD = 1'b1;
      tick();
      nd++;
    end
    total++;
    if (nd !== 31) begin bad++; $display("[TB] FAIL cnt_saturate_up: got downs=%0d want 31", nd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    dp_if.A = '0;
    dp_if.B = '0;
    clear_ctrl();
    test_reset();
    test_small_ops();
    test_all_ones();
    test_zero_operand();
    test_priority();
    test_mid_reset();
    test_counter_bounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
